// File: rtl/write_param_recv_if.sv
// Write-bus interface carried between parameter writers and the responder.
// The master drives address, data and valid; the slave answers with ready.
interface w_busif;
    logic [31:0] data;
    logic [7:0]  addr;
    logic        valid;
    logic        ready;

    modport master (output data, output addr, output valid, input ready);
    modport slave  (input data, input addr, input valid, output ready);
endinterface

// File: rtl/write_param_recv.sv
// write_param_recv: terminates w_busif writes into a bank of 32-bit parameter
// registers. Each register has a one-cycle update strobe and a staleness
// watchdog. Out-of-range writes raise a sticky flag and bump a saturating
// counter. The FSM takes one write every two cycles: IDLE accepts, COMMIT applies.
module write_param_recv #(
    parameter logic [7:0] BASE_ADDR     = 8'h00,
    parameter int         NUM_REGS      = 4,
    parameter int         STALE_TIMEOUT = 2000000
) (
    input  logic                     clk,
    input  logic                     rst,
    w_busif.slave                    w_s,
    output logic [NUM_REGS*32-1:0]   param,
    output logic [NUM_REGS-1:0]      upd,
    output logic [NUM_REGS-1:0]      stale,
    output logic                     err_addr,
    output logic [7:0]               err_cnt
);

    // Counter wide enough to hold STALE_TIMEOUT itself (the saturation value).
    localparam int                CNT_W      = (STALE_TIMEOUT < 2) ? 1 : $clog2(STALE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(STALE_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO_C = CNT_W'(0);
    localparam logic [7:0]        NUM_REGS_C = 8'(NUM_REGS);
    localparam logic              STALE_EN_C = (STALE_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               state_r;
    logic                 ready_r;
    logic [7:0]           addr_r;
    logic [31:0]          data_r;
    logic [31:0]          param_r [NUM_REGS];
    logic [NUM_REGS-1:0]  upd_r;
    logic [NUM_REGS-1:0]  stale_r;
    logic                 err_addr_r;
    logic [7:0]           err_cnt_r;
    logic [CNT_W-1:0]     stale_cnt_r   [NUM_REGS];
    logic [CNT_W-1:0]     stale_cnt_nxt_s [NUM_REGS];

    logic [7:0]           idx_s;
    logic                 in_range_s;
    logic                 commit_s;
    logic [NUM_REGS-1:0]  wr_en_s;

    // Decode the latched address into a per-register write enable during COMMIT.
    always_comb begin
        idx_s      = addr_r - BASE_ADDR;   // wraps modulo 256 by construction
        in_range_s = (idx_s < NUM_REGS_C);
        commit_s   = (state_r == ST_COMMIT);
        wr_en_s    = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en_s[i] = commit_s && in_range_s && (idx_s == 8'(i));
        end
    end

    // Next stale-counter value: a write clears, otherwise count up to the timeout and hold.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            stale_cnt_nxt_s[i] = stale_cnt_r[i];
            if (wr_en_s[i]) begin
                stale_cnt_nxt_s[i] = CNT_ZERO_C;
            end else if (stale_cnt_r[i] < TIMEOUT_C) begin
                stale_cnt_nxt_s[i] = stale_cnt_r[i] + CNT_ONE_C;
            end else begin
                stale_cnt_nxt_s[i] = stale_cnt_r[i];
            end
        end
    end

    // Handshake FSM; also applies the latched write, the update strobes and error tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_INIT;
            ready_r    <= 1'b0;
            addr_r     <= 8'h00;
            data_r     <= 32'h0000_0000;
            upd_r      <= {NUM_REGS{1'b0}};
            err_addr_r <= 1'b0;
            err_cnt_r  <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                param_r[i] <= 32'h0000_0000;
            end
        end else begin
            // wr_en_s is only ever non-zero in COMMIT, so this is a single-cycle pulse.
            upd_r <= wr_en_s;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s[i]) begin
                    param_r[i] <= data_r;
                end
            end
            case (state_r)
                ST_INIT: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_s.valid && ready_r) begin
                        addr_r  <= w_s.addr;
                        data_r  <= w_s.data;
                        ready_r <= 1'b0;
                        state_r <= ST_COMMIT;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    if (!in_range_s) begin
                        err_addr_r <= 1'b1;
                        if (err_cnt_r != 8'hFF) begin
                            err_cnt_r <= err_cnt_r + 8'h01;
                        end
                    end
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Staleness watchdogs; stale is registered from the next counter value so it
    // drops on the same edge that raises the matching update strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_r <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                stale_cnt_r[i] <= CNT_ZERO_C;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                stale_cnt_r[i] <= stale_cnt_nxt_s[i];
                stale_r[i]     <= STALE_EN_C && (stale_cnt_nxt_s[i] == TIMEOUT_C);
            end
        end
    end

    // Flatten the register bank onto the output bus.
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_param
            assign param[32*g +: 32] = param_r[g];
        end
    endgenerate

    assign w_s.ready = ready_r;
    assign upd       = upd_r;
    assign stale     = stale_r;
    assign err_addr  = err_addr_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_write_param_recv.sv
// Directed bench for write_param_recv with STALE_TIMEOUT=100 and 4 registers at base 0.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_write_param_recv;

    logic          clk;
    logic          rst;
    logic [127:0]  param;
    logic [3:0]    upd;
    logic [3:0]    stale;
    logic          err_addr;
    logic [7:0]    err_cnt;

    int vec_cnt;
    int miscompares;

    w_busif bus ();

    write_param_recv #(
        .BASE_ADDR     (8'h00),
        .NUM_REGS      (4),
        .STALE_TIMEOUT (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_s      (bus),
        .param    (param),
        .upd      (upd),
        .stale    (stale),
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return param[32*i +: 32];
    endfunction

    // Wait (bounded) for ready, handshake one write, drop valid during COMMIT and
    // return at the falling edge just after the apply edge.
    task automatic send(input logic [7:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check("hs_timeout", 64'd0, 64'd1);
        bus.addr  = a;
        bus.data  = d;
        bus.valid = 1'b1;
        @(negedge clk);
        check("commit_ready", {63'd0, bus.ready}, 64'd0);
        bus.valid = 1'b0;
        bus.addr  = 8'h02;          // garbage outside the handshake must be ignored
        bus.data  = 32'hFFFF_FFFF;
        @(negedge clk);
    endtask

    initial begin
        vec_cnt     = 0;
        miscompares = 0;
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.addr  = 8'h00;
        bus.data  = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, bus.ready}, 64'd0);
        check("rst_param", {32'd0, param[31:0] | param[63:32] | param[95:64] | param[127:96]}, 64'd0);
        check("rst_upd",   {60'd0, upd}, 64'd0);
        check("rst_stale", {60'd0, stale}, 64'd0);
        check("rst_err",   {55'd0, err_addr, err_cnt}, 64'd0);

        // Release: one INIT cycle with ready low, then ready high
        rst = 1'b0;
        #1;
        check("init_ready", {63'd0, bus.ready}, 64'd0);
        @(negedge clk);            // edge 1 after release
        check("idle_ready", {63'd0, bus.ready}, 64'd1);

        // Stale with no writes: counter reaches 100 at edge 100 after release
        repeat (98) @(negedge clk); // edge 99
        check("stale_pre",  {60'd0, stale}, 64'd0);
        @(negedge clk);            // edge 100
        check("stale_all",  {60'd0, stale}, 64'hF);

        // Single write to reg 2
        send(8'h02, 32'hDEAD_BEEF);
        check("w2_param",  {32'd0, reg_of(2)}, 64'hDEAD_BEEF);
        check("w2_upd",    {60'd0, upd}, 64'h4);
        check("w2_ready",  {63'd0, bus.ready}, 64'd1);
        check("w2_stale",  {60'd0, stale}, 64'hB);
        check("w2_others", {32'd0, reg_of(0) | reg_of(1) | reg_of(3)}, 64'd0);
        @(negedge clk);
        check("w2_upd_end", {60'd0, upd}, 64'd0);
        check("w2_hold",    {32'd0, reg_of(2)}, 64'hDEAD_BEEF);

        // Back-to-back writes to reg 0 with valid held high: data 1, 2, 3
        bus.addr  = 8'h00;
        bus.data  = 32'd1;
        bus.valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);        // just after handshake
            check("b2b_commit_ready", {63'd0, bus.ready}, 64'd0);
            check("b2b_commit_upd",   {60'd0, upd}, 64'd0);
            if (k == 3) bus.valid = 1'b0;
            else        bus.data  = 32'(k + 1);
            @(negedge clk);        // just after apply
            check("b2b_upd",   {60'd0, upd}, 64'h1);
            check("b2b_param", {32'd0, reg_of(0)}, 64'(k));
            check("b2b_ready", {63'd0, bus.ready}, 64'd1);
        end
        @(negedge clk);
        check("b2b_final", {32'd0, reg_of(0)}, 64'd3);
        check("b2b_quiet", {60'd0, upd}, 64'd0);

        // Highest in-range address
        send(8'h03, 32'hA5A5_0003);
        check("w3_upd",   {60'd0, upd}, 64'h8);
        check("w3_param", {32'd0, reg_of(3)}, 64'hA5A5_0003);
        check("w3_err",   {63'd0, err_addr}, 64'd0);

        // First out-of-range address
        send(8'h04, 32'h1234_5678);
        check("oor4_upd",  {60'd0, upd}, 64'd0);
        check("oor4_err",  {63'd0, err_addr}, 64'd1);
        check("oor4_cnt",  {56'd0, err_cnt}, 64'd1);
        check("oor4_regs", {param[127:96], param[31:0]}, {32'hA5A5_0003, 32'd3});

        // Address 7 repeated 300 times: counter saturates
        send(8'h07, 32'h0BAD_0007);
        check("oor7_cnt", {56'd0, err_cnt}, 64'd2);
        check("oor7_upd", {60'd0, upd}, 64'd0);
        for (int k = 0; k < 299; k++) send(8'h07, 32'h0BAD_0007);
        check("sat_cnt",  {56'd0, err_cnt}, 64'd255);
        check("sat_flag", {63'd0, err_addr}, 64'd1);
        check("sat_regs", {32'd0, reg_of(2)}, 64'hDEAD_BEEF);
        check("sat_stale", {60'd0, stale}, 64'hF);

        // Write reg 1: stale[1] drops with upd[1], re-asserts 100 edges later
        send(8'h01, 32'h0000_0011);
        check("w1_upd",   {60'd0, upd}, 64'h2);
        check("w1_stale", {60'd0, stale}, 64'hD);
        check("w1_param", {32'd0, reg_of(1)}, 64'h11);
        repeat (99) @(negedge clk);
        check("w1_stale_99",  {63'd0, stale[1]}, 64'd0);
        @(negedge clk);
        check("w1_stale_100", {63'd0, stale[1]}, 64'd1);

        // Reset asserted during COMMIT of a write to reg 0 with data 5
        while (!bus.ready) @(negedge clk);
        bus.addr  = 8'h00;
        bus.data  = 32'd5;
        bus.valid = 1'b1;
        @(negedge clk);
        check("rc_commit_ready", {63'd0, bus.ready}, 64'd0);
        rst = 1'b1;
        #1;
        bus.valid = 1'b0;
        check("rc_param", {32'd0, param[31:0] | param[63:32] | param[95:64] | param[127:96]}, 64'd0);
        check("rc_flags", {47'd0, err_addr, err_cnt, upd, stale}, 64'd0);
        check("rc_ready", {63'd0, bus.ready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("rc_reg0_held", {32'd0, reg_of(0)}, 64'd0);
        rst = 1'b0;
        #1;
        check("rc_init_ready", {63'd0, bus.ready}, 64'd0);
        @(negedge clk);
        check("rc_idle_ready", {63'd0, bus.ready}, 64'd1);
        check("rc_reg0_after", {32'd0, reg_of(0)}, 64'd0);
        send(8'h00, 32'h0000_0009);
        check("rc_fresh_upd",   {60'd0, upd}, 64'h1);
        check("rc_fresh_param", {32'd0, reg_of(0)}, 64'h9);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
